// File: rtl/my_mod_pkg.sv
// Shared widths, result type and helpers for the my_mod block-average unit.
// Optional build macro MY_MOD_SATURATE_EN selects saturating output via sat9().
package my_mod_pkg;

   // Sample and gain widths; a product is DATA_W + GAIN_W bits wide.
   localparam int unsigned DATA_W  = 9;
   localparam int unsigned GAIN_W  = 8;
   localparam int unsigned ProdW   = DATA_W + GAIN_W;

   // Largest supported window exponent and the matching accumulator width.
   localparam int unsigned MaxY    = 7;
   localparam int unsigned MaxAccW = ProdW + MaxY;

   // Output of the saturating result stage: clamped value plus clamp flag.
   typedef struct packed {
      logic [DATA_W-1:0] val;
      logic              sat;
   } sat_res_t;

   // Accumulator width for a window of 2^y samples; large enough that a full
   // window of maximal products cannot overflow.
   function automatic int unsigned acc_w(input int unsigned y);
      return DATA_W + GAIN_W + y;
   endfunction

   // Clamp a shifted window sum to the 9-bit output range.
   function automatic sat_res_t sat9(input logic [MaxAccW-1:0] v);
      sat_res_t r;
      if (|v[MaxAccW-1:DATA_W]) begin
         r.val = '1;
         r.sat = 1'b1;
      end else begin
         r.val = v[DATA_W-1:0];
         r.sat = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/my_mod_wincnt.sv
// Window position counter for my_mod: counts accepted samples 0..2^Y-1 and
// flags the terminal position so the top can close the window.
module my_mod_wincnt #(
   parameter int unsigned Y = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       adv_i,
   output logic [Y:0] cnt_o,
   output logic       last_o
);

   localparam int unsigned CntW    = Y + 1;
   localparam logic [Y:0]  LastVal = CntW'((1 << Y) - 1);

   logic [Y:0] cnt_q, cnt_d;

   // With Y=0 LastVal is 0, so the counter never leaves 0 and every sample
   // is the last of its window.
   assign last_o = (cnt_q == LastVal);
   assign cnt_o  = cnt_q;

   // Advance on each accepted sample, wrapping after the terminal position.
   always_comb begin
      cnt_d = cnt_q;
      if (adv_i) begin
         cnt_d = last_o ? '0 : cnt_q + CntW'(1);
      end
   end

   // Window position register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/my_mod.sv
// my_mod: block-average unit. Accumulates foo*X over windows of 2^Y accepted
// samples and emits the scaled mean as a one-cycle avg_valid pulse.
// Build macro MY_MOD_SATURATE_EN: saturate the mean to 511 and add avg_sat;
// without it the mean wraps to its low 9 bits.
module my_mod
   import my_mod_pkg::*;
#(
   parameter int unsigned X = 1,
   parameter int unsigned Y = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] foo,
   input  logic              foo_valid,
   output logic [DATA_W-1:0] avg,
   output logic              avg_valid,
`ifdef MY_MOD_SATURATE_EN
   output logic              avg_sat,
`endif
   output logic [Y:0]        win_cnt
);

   localparam int unsigned       AccW = acc_w(Y);
   localparam logic [GAIN_W-1:0] Gain = GAIN_W'(X);

   logic [AccW-1:0]   acc_q, acc_d;
   logic [DATA_W-1:0] avg_q, avg_d;
   logic              avg_valid_q, avg_valid_d;
   logic              sat_q, sat_d;

   logic [ProdW-1:0]  prod;
   logic [AccW-1:0]   sum;
   logic              win_last;
   logic [DATA_W-1:0] res;
   logic              res_sat;

   my_mod_wincnt #(
      .Y (Y)
   ) u_wincnt (
      .clk_i  (clk),
      .rst_i  (rst),
      .adv_i  (foo_valid),
      .cnt_o  (win_cnt),
      .last_o (win_last)
   );

   // Both operands widened to the full product width so nothing is lost.
   assign prod = ProdW'(foo) * ProdW'(Gain);
   assign sum  = acc_q + AccW'(prod);

`ifdef MY_MOD_SATURATE_EN
   sat_res_t sat_res;

   assign sat_res = sat9(MaxAccW'(sum >> Y));
   assign res     = sat_res.val;
   assign res_sat = sat_res.sat;
`else
   assign res     = DATA_W'(sum >> Y);
   assign res_sat = 1'b0;
`endif

   // Accumulate accepted samples; on the last one publish the mean and clear.
   always_comb begin
      acc_d       = acc_q;
      avg_d       = avg_q;
      avg_valid_d = 1'b0;
      sat_d       = 1'b0;
      if (foo_valid) begin
         if (win_last) begin
            acc_d       = '0;
            avg_d       = res;
            avg_valid_d = 1'b1;
            sat_d       = res_sat;
         end else begin
            acc_d = sum;
         end
      end
   end

   // State and output registers; reset discards any sample presented with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         avg_q       <= avg_d;
         avg_valid_q <= avg_valid_d;
         sat_q       <= sat_d;
      end
   end

   assign avg       = avg_q;
   assign avg_valid = avg_valid_q;

`ifdef MY_MOD_SATURATE_EN
   assign avg_sat = sat_q;
`else
   // Clamp flag has no port in the wrapping build.
   logic unused_sat;
   assign unused_sat = sat_q ^ res_sat;
`endif

endmodule

// File: tb/tb_my_mod.sv
// Self-checking bench for my_mod: directed vector table on X=1/Y=2, hand
// sequences for X=3/Y=0 and X=255/Y=7, then randomized traffic on all three
// instances against a window-sum reference model.
module tb_my_mod;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 0: X=1, Y=2
   logic       rst0, v0, av0;
   logic [8:0] foo0, avg0;
   logic [2:0] wc0;
   // Instance 1: X=3, Y=0
   logic       rst1, v1, av1;
   logic [8:0] foo1, avg1;
   logic [0:0] wc1;
   // Instance 2: X=255, Y=7
   logic       rst2, v2, av2;
   logic [8:0] foo2, avg2;
   logic [7:0] wc2;
`ifdef MY_MOD_SATURATE_EN
   logic       sat0, sat1, sat2;
`endif

   my_mod #(.X(1), .Y(2)) u_dut0 (
      .clk       (clk),
      .rst       (rst0),
      .foo       (foo0),
      .foo_valid (v0),
      .avg       (avg0),
      .avg_valid (av0),
`ifdef MY_MOD_SATURATE_EN
      .avg_sat   (sat0),
`endif
      .win_cnt   (wc0)
   );

   my_mod #(.X(3), .Y(0)) u_dut1 (
      .clk       (clk),
      .rst       (rst1),
      .foo       (foo1),
      .foo_valid (v1),
      .avg       (avg1),
      .avg_valid (av1),
`ifdef MY_MOD_SATURATE_EN
      .avg_sat   (sat1),
`endif
      .win_cnt   (wc1)
   );

   my_mod #(.X(255), .Y(7)) u_dut2 (
      .clk       (clk),
      .rst       (rst2),
      .foo       (foo2),
      .foo_valid (v2),
      .avg       (avg2),
      .avg_valid (av2),
`ifdef MY_MOD_SATURATE_EN
      .avg_sat   (sat2),
`endif
      .win_cnt   (wc2)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed vectors for instance 0 (X=1, Y=2)
   typedef struct {
      bit rst;
      bit v;
      int foo;
      int cnt;
      bit valid;
      int avg;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit r, bit v, int f, int c, bit vl, int a);
      vec_t e;
      e.rst = r; e.v = v; e.foo = f; e.cnt = c; e.valid = vl; e.avg = a;
      tbl.push_back(e);
   endfunction

   // Reference model: per-instance gain, window exponent and window contents
   int     gx[3] = '{1, 3, 255};
   int     gy[3] = '{2, 0, 7};
   longint m_sum[3];
   int     m_n[3];
   int     m_avg[3];
   bit     m_valid[3];
   bit     m_sat[3];

   task automatic model_step(input int k, input bit r, input bit v, input int f);
      longint mean;
      m_valid[k] = 1'b0;
      m_sat[k]   = 1'b0;
      if (r) begin
         m_sum[k] = 0;
         m_n[k]   = 0;
         m_avg[k] = 0;
      end else if (v) begin
         m_sum[k] += longint'(f) * gx[k];
         m_n[k]++;
         if (m_n[k] == (1 << gy[k])) begin
            mean = m_sum[k] / (longint'(1) << gy[k]);
`ifdef MY_MOD_SATURATE_EN
            m_avg[k] = (mean > 511) ? 511 : int'(mean);
            m_sat[k] = (mean > 511);
`else
            m_avg[k] = int'(mean % 512);
`endif
            m_valid[k] = 1'b1;
            m_sum[k]   = 0;
            m_n[k]     = 0;
         end
      end
   endtask

   task automatic drive(input int k, input bit r, input bit v, input int f);
      case (k)
         0: begin rst0 = r; v0 = v; foo0 = 9'(f); end
         1: begin rst1 = r; v1 = v; foo1 = 9'(f); end
         default: begin rst2 = r; v2 = v; foo2 = 9'(f); end
      endcase
   endtask

   task automatic get_outs(input int k, output logic [31:0] a, output logic [31:0] vl,
                           output logic [31:0] c, output logic [31:0] s);
      s = 0;
      case (k)
         0: begin a = 32'(avg0); vl = 32'(av0); c = 32'(wc0);
`ifdef MY_MOD_SATURATE_EN
            s = 32'(sat0);
`endif
         end
         1: begin a = 32'(avg1); vl = 32'(av1); c = 32'(wc1);
`ifdef MY_MOD_SATURATE_EN
            s = 32'(sat1);
`endif
         end
         default: begin a = 32'(avg2); vl = 32'(av2); c = 32'(wc2);
`ifdef MY_MOD_SATURATE_EN
            s = 32'(sat2);
`endif
         end
      endcase
   endtask

   initial begin
      logic [31:0] a, vl, c, s;
      int          exp_avg;

      rst0 = 1'b1; v0 = 1'b0; foo0 = '0;
      rst1 = 1'b1; v1 = 1'b0; foo1 = '0;
      rst2 = 1'b1; v2 = 1'b0; foo2 = '0;

      // Reset with a sample present, then samples 4,8,12,16 -> 10
      add(1, 1, 300, 0, 0, 0);
      add(0, 0, 0,   0, 0, 0);
      add(0, 1, 4,   1, 0, 0);
      add(0, 1, 8,   2, 0, 0);
      add(0, 1, 12,  3, 0, 0);
      add(0, 1, 16,  0, 1, 10);
      add(0, 0, 0,   0, 0, 10);
      // Reset, then the same window with idle gaps
      add(1, 0, 0,   0, 0, 0);
      add(0, 1, 4,   1, 0, 0);
      add(0, 0, 0,   1, 0, 0);
      add(0, 1, 8,   2, 0, 0);
      add(0, 0, 0,   2, 0, 0);
      add(0, 0, 0,   2, 0, 0);
      add(0, 1, 12,  3, 0, 0);
      add(0, 0, 0,   3, 0, 0);
      add(0, 1, 16,  0, 1, 10);
      add(0, 0, 0,   0, 0, 10);
      // Mid-window reset with a sample present, then 4 x 7 -> 7
      add(0, 1, 100, 1, 0, 10);
      add(0, 1, 100, 2, 0, 10);
      add(1, 1, 100, 0, 0, 0);
      add(0, 1, 7,   1, 0, 0);
      add(0, 1, 7,   2, 0, 0);
      add(0, 1, 7,   3, 0, 0);
      add(0, 1, 7,   0, 1, 7);
      // Back-to-back windows of 511
      add(0, 1, 511, 1, 0, 7);
      add(0, 1, 511, 2, 0, 7);
      add(0, 1, 511, 3, 0, 7);
      add(0, 1, 511, 0, 1, 511);
      add(0, 1, 511, 1, 0, 511);
      add(0, 1, 511, 2, 0, 511);
      add(0, 1, 511, 3, 0, 511);
      add(0, 1, 511, 0, 1, 511);
      add(0, 0, 0,   0, 0, 511);

      foreach (tbl[i]) begin
         drive(0, tbl[i].rst, tbl[i].v, tbl[i].foo);
         tick();
         chk($sformatf("vec%0d win_cnt", i), 32'(wc0), 32'(tbl[i].cnt));
         chk($sformatf("vec%0d avg_valid", i), 32'(av0), 32'(tbl[i].valid));
         chk($sformatf("vec%0d avg", i), 32'(avg0), 32'(tbl[i].avg));
`ifdef MY_MOD_SATURATE_EN
         chk($sformatf("vec%0d avg_sat", i), 32'(sat0), 32'd0);
`endif
      end
      drive(0, 1'b1, 1'b0, 0);

      // X=3, Y=0: every sample closes a window
      drive(1, 1'b1, 1'b1, 5);
      tick();
      chk("y0 reset avg", 32'(avg1), 32'd0);
      chk("y0 reset valid", 32'(av1), 32'd0);
      drive(1, 1'b0, 1'b1, 5);
      tick();
      chk("y0 5 avg", 32'(avg1), 32'd15);
      chk("y0 5 valid", 32'(av1), 32'd1);
      chk("y0 5 win_cnt", 32'(wc1), 32'd0);
      drive(1, 1'b0, 1'b0, 0);
      tick();
      chk("y0 idle valid", 32'(av1), 32'd0);
      chk("y0 idle avg", 32'(avg1), 32'd15);
      drive(1, 1'b0, 1'b1, 200);
      tick();
`ifdef MY_MOD_SATURATE_EN
      exp_avg = 511;
      chk("y0 200 avg_sat", 32'(sat1), 32'd1);
`else
      exp_avg = 88;
`endif
      chk("y0 200 avg", 32'(avg1), 32'(exp_avg));
      chk("y0 200 valid", 32'(av1), 32'd1);
      drive(1, 1'b0, 1'b0, 0);
      tick();
      chk("y0 200 idle valid", 32'(av1), 32'd0);
`ifdef MY_MOD_SATURATE_EN
      chk("y0 200 idle avg_sat", 32'(sat1), 32'd0);
`endif
      drive(1, 1'b1, 1'b0, 0);

      // X=255, Y=7: 128 samples of 511, no internal overflow
      drive(2, 1'b1, 1'b0, 0);
      tick();
      drive(2, 1'b0, 1'b1, 511);
      for (int i = 0; i < 128; i++) begin
         tick();
         if (i < 127) begin
            chk($sformatf("max s%0d valid", i), 32'(av2), 32'd0);
            chk($sformatf("max s%0d win_cnt", i), 32'(wc2), 32'(i + 1));
         end
      end
`ifdef MY_MOD_SATURATE_EN
      exp_avg = 511;
      chk("max avg_sat", 32'(sat2), 32'd1);
`else
      exp_avg = 257;
`endif
      chk("max avg", 32'(avg2), 32'(exp_avg));
      chk("max valid", 32'(av2), 32'd1);
      chk("max win_cnt", 32'(wc2), 32'd0);
      drive(2, 1'b0, 1'b0, 0);
      tick();
      chk("max idle valid", 32'(av2), 32'd0);

      // Randomized traffic on all instances against the model
      for (int k = 0; k < 3; k++) begin
         drive(k, 1'b1, 1'b0, 0);
         model_step(k, 1'b1, 1'b0, 0);
      end
      tick();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int k = 0; k < 3; k++) begin
            bit r, v;
            int f;
            r = ($urandom_range(63) == 0);
            v = ($urandom_range(9) < 7);
            f = ($urandom_range(3) == 0) ? 511 - int'($urandom_range(3)) : int'($urandom_range(511));
            drive(k, r, v, f);
            model_step(k, r, v, f);
         end
         tick();
         for (int k = 0; k < 3; k++) begin
            get_outs(k, a, vl, c, s);
            chk($sformatf("rnd%0d.%0d avg", k, cyc), a, 32'(m_avg[k]));
            chk($sformatf("rnd%0d.%0d avg_valid", k, cyc), vl, 32'(m_valid[k]));
            chk($sformatf("rnd%0d.%0d win_cnt", k, cyc), c, 32'(m_n[k]));
`ifdef MY_MOD_SATURATE_EN
            chk($sformatf("rnd%0d.%0d avg_sat", k, cyc), s, 32'(m_sat[k]));
`endif
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
